register_file: RTL and testbench

//  Architectural register file of the Solix-16 CPU.
//  - 8 general-purpose 16-bit registers r0..r7, with two asynchronous read ports (rs, rt) and one synchronous write port (rd).
//  - Dedicated PC, SP and FLAGS registers, each with its own write strobe and an always-visible output.
//  - Sits between decode/ALU and the control unit; holds all CPU-visible state.

---
 rtl/register_file.sv | 67 ++++++
 tb/tb_register_file.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Solix-16 architectural register file.
// Holds eight GPRs plus PC, SP and FLAGS, with two combinational read ports.
module register_file #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_GPR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] sp_out,
    output logic [DATA_W-1:0] flags_out,
    input  logic              pc_wr,
    input  logic              sp_wr,
    input  logic              flags_wr,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] sp_in,
    input  logic [DATA_W-1:0] flags_in
);

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en && (int'(rd_addr) < NUM_GPR)) begin
            gpr[rd_addr[$clog2(NUM_GPR)-1:0]] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            sp_q    <= '0;
            flags_q <= '0;
        end else begin
            if (pc_wr)    pc_q    <= pc_in;
            if (sp_wr)    sp_q    <= sp_in;
            if (flags_wr) flags_q <= flags_in;
        end
    end

    // Unimplemented addresses read as zero; no bypass of a pending write.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (int'(rs_addr) < NUM_GPR) rs_data = gpr[rs_addr[$clog2(NUM_GPR)-1:0]];
        if (int'(rt_addr) < NUM_GPR) rt_data = gpr[rt_addr[$clog2(NUM_GPR)-1:0]];
    end

    assign pc_out    = pc_q;
    assign sp_out    = sp_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file.
// Each task drives one scenario and checks results inline.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        wr_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] pc_out;
    logic [15:0] sp_out;
    logic [15:0] flags_out;
    logic        pc_wr;
    logic        sp_wr;
    logic        flags_wr;
    logic [15:0] pc_in;
    logic [15:0] sp_in;
    logic [15:0] flags_in;

    int n_cmp;
    int n_bad;

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pc_out    (pc_out),
        .sp_out    (sp_out),
        .flags_out (flags_out),
        .pc_wr     (pc_wr),
        .sp_wr     (sp_wr),
        .flags_wr  (flags_wr),
        .pc_in     (pc_in),
        .sp_in     (sp_in),
        .flags_in  (flags_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_gpr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        rd_addr = a;
        rd_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        rs_addr = 4'd0;
        rt_addr = 4'd7;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_r0 got %h exp %h", rs_data, 16'h0000);
        end
        n_cmp++;
        if (rt_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_r7 got %h exp %h", rt_data, 16'h0000);
        end
        n_cmp++;
        if (pc_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_pc got %h exp %h", pc_out, 16'h0000);
        end
        n_cmp++;
        if (sp_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_sp got %h exp %h", sp_out, 16'h0000);
        end
        n_cmp++;
        if (flags_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_flags got %h exp %h", flags_out, 16'h0000);
        end
    endtask

    task automatic test_two_port_read();
        write_gpr(4'd1, 16'h1234);
        write_gpr(4'd3, 16'hABCD);
        rs_addr = 4'd1;
        rt_addr = 4'd3;
        #1;
        n_cmp++;
        if (rs_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL rd_r1 got %h exp %h", rs_data, 16'h1234);
        end
        n_cmp++;
        if (rt_data !== 16'hABCD) begin
            n_bad++;
            $display("FAIL rd_r3 got %h exp %h", rt_data, 16'hABCD);
        end
        rs_addr = 4'd3;
        #1;
        n_cmp++;
        if (rs_data !== 16'hABCD || rt_data !== 16'hABCD) begin
            n_bad++;
            $display("FAIL same_addr got %h/%h exp %h", rs_data, rt_data, 16'hABCD);
        end
    endtask

    task automatic test_all_gpr();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            write_gpr(4'(i), 16'h0100 + 16'(i));
        end
        for (int i = 0; i < 8; i++) begin
            exp = 16'h0100 + 16'(i);
            rs_addr = 4'(i);
            rt_addr = 4'(7 - i);
            #1;
            n_cmp++;
            if (rs_data !== exp) begin
                n_bad++;
                $display("FAIL gpr_rs r%0d got %h exp %h", i, rs_data, exp);
            end
            n_cmp++;
            if (rt_data !== 16'h0107 - 16'(i)) begin
                n_bad++;
                $display("FAIL gpr_rt r%0d got %h exp %h",
                         7 - i, rt_data, 16'h0107 - 16'(i));
            end
        end
    endtask

    task automatic test_special_regs();
        pc_in = 16'h0100;
        pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        n_cmp++;
        if (pc_out !== 16'h0100) begin
            n_bad++;
            $display("FAIL pc_load got %h exp %h", pc_out, 16'h0100);
        end
        pc_in = pc_out + 16'd1;
        pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        n_cmp++;
        if (pc_out !== 16'h0101) begin
            n_bad++;
            $display("FAIL pc_inc got %h exp %h", pc_out, 16'h0101);
        end
        sp_in = 16'hFFFF;
        sp_wr = 1'b1;
        tick();
        sp_wr = 1'b0;
        n_cmp++;
        if (sp_out !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sp_load got %h exp %h", sp_out, 16'hFFFF);
        end
        sp_in = sp_out - 16'd1;
        sp_wr = 1'b1;
        tick();
        sp_wr = 1'b0;
        n_cmp++;
        if (sp_out !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sp_dec got %h exp %h", sp_out, 16'hFFFE);
        end
        flags_in = 16'h000F;
        flags_wr = 1'b1;
        tick();
        flags_wr = 1'b0;
        n_cmp++;
        if (flags_out !== 16'h000F) begin
            n_bad++;
            $display("FAIL flags_load got %h exp %h", flags_out, 16'h000F);
        end
        // Strobes off: all hold even with new inputs presented.
        pc_in    = 16'h1111;
        sp_in    = 16'h2222;
        flags_in = 16'hF3F0;
        tick();
        n_cmp++;
        if (pc_out !== 16'h0101 || sp_out !== 16'hFFFE || flags_out !== 16'h000F) begin
            n_bad++;
            $display("FAIL special_hold got %h/%h/%h exp 0101/fffe/000f",
                     pc_out, sp_out, flags_out);
        end
        // All strobes together with a GPR write.
        pc_wr    = 1'b1;
        sp_wr    = 1'b1;
        flags_wr = 1'b1;
        write_gpr(4'd6, 16'h6666);
        pc_wr    = 1'b0;
        sp_wr    = 1'b0;
        flags_wr = 1'b0;
        rs_addr  = 4'd6;
        #1;
        n_cmp++;
        if (pc_out !== 16'h1111 || sp_out !== 16'h2222 ||
            flags_out !== 16'hF3F0 || rs_data !== 16'h6666) begin
            n_bad++;
            $display("FAIL concurrent got %h/%h/%h/%h exp 1111/2222/f3f0/6666",
                     pc_out, sp_out, flags_out, rs_data);
        end
        // Independent strobe: only SP loads.
        sp_in = 16'h0042;
        sp_wr = 1'b1;
        tick();
        sp_wr = 1'b0;
        n_cmp++;
        if (pc_out !== 16'h1111 || sp_out !== 16'h0042 || flags_out !== 16'hF3F0) begin
            n_bad++;
            $display("FAIL sp_only got %h/%h/%h exp 1111/0042/f3f0",
                     pc_out, sp_out, flags_out);
        end
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        rt_addr = 4'd5;
        wr_en   = 1'b1;
        rd_addr = 4'd5;
        rd_data = 16'h5555;
        #1;
        n_cmp++;
        if (rt_data !== 16'h0105) begin
            n_bad++;
            $display("FAIL pre_edge got %h exp %h", rt_data, 16'h0105);
        end
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (rt_data !== 16'h5555) begin
            n_bad++;
            $display("FAIL post_edge got %h exp %h", rt_data, 16'h5555);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp;
        write_gpr(4'd12, 16'hDEAD);
        write_gpr(4'd8, 16'hBEEF);
        rs_addr = 4'd12;
        rt_addr = 4'd15;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL oor_read got %h/%h exp 0000/0000", rs_data, rt_data);
        end
        // Expected GPR contents after previous tests.
        for (int i = 0; i < 8; i++) begin
            exp = (i == 5) ? 16'h5555 : (i == 6) ? 16'h6666 : 16'h0100 + 16'(i);
            rs_addr = 4'(i);
            #1;
            n_cmp++;
            if (rs_data !== exp) begin
                n_bad++;
                $display("FAIL oor_intact r%0d got %h exp %h", i, rs_data, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        // Pending write must be discarded by reset.
        wr_en   = 1'b1;
        rd_addr = 4'd2;
        rd_data = 16'h7777;
        rst     = 1'b1;
        #1;
        rs_addr = 4'd0;
        rt_addr = 4'd5;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_gpr got %h/%h exp 0000/0000", rs_data, rt_data);
        end
        n_cmp++;
        if (pc_out !== 16'h0000 || sp_out !== 16'h0000 || flags_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_special got %h/%h/%h exp 0000/0000/0000",
                     pc_out, sp_out, flags_out);
        end
        pc_wr = 1'b1;
        tick();
        pc_wr = 1'b0;
        wr_en = 1'b0;
        rst   = 1'b0;
        rs_addr = 4'd2;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000 || pc_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_override got %h/%h exp 0000/0000", rs_data, pc_out);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        rs_addr  = '0;
        rt_addr  = '0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        pc_wr    = 1'b0;
        sp_wr    = 1'b0;
        flags_wr = 1'b0;
        pc_in    = '0;
        sp_in    = '0;
        flags_in = '0;
        #2;
        test_reset();
        test_two_port_read();
        test_all_gpr();
        test_special_regs();
        test_no_bypass();
        test_out_of_range();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
